imem_fetch_sequencer: RTL and testbench
=======================================

Name: imem_fetch_sequencer

Overview:
Fetch controller that owns the program counter and sequences reads from the byte-addressed, combinational-read instruction memory. The memory returns 4 big-endian bytes at PC..PC+3. Fetched words are buffered with their PCs in a small FIFO toward decode, using a valid/ready handshake. The block also handles jump/branch redirects, halts on the all-zero end-of-program word, and faults on illegal fetch addresses.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
MEM_BYTES, 36, instruction memory size in bytes; legal fetch requires PC+3 < MEM_BYTES
QDEPTH, 2, fetch FIFO depth in entries (>=2, power of 2)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_pc  out  32  byte address driven to instruction memory (equals current PC)
imem_instr  in  32  instruction word returned combinationally for imem_pc
redirect_valid  in  1  one-cycle pulse: flush and restart fetch at redirect_target
redirect_target  in  32  byte address of new PC
instr_valid  out  1  FIFO head valid
instr_ready  in  1  decode accepts head this cycle
instr_out  out  32  FIFO head instruction word
instr_pc  out  32  byte address of FIFO head
halted  out  1  high in HALT state
fault  out  1  high in FAULT state (sticky)

Behaviour:
- Reset (sync, reset=1 at edge): PC<=RESET_PC, FIFO empty, state RUN. Outputs after reset: instr_valid=0, instr_out=0, instr_pc=0, halted=0, fault=0, imem_pc=RESET_PC.
- States: RUN, HALT, FAULT.
- Legal PC: PC[1:0]==0 and PC+3 < MEM_BYTES (compute in 33 bits, no wrap).
- RUN, legal PC, push allowed (count<QDEPTH, or count==QDEPTH with a pop this cycle):
  - imem_instr != 0: push {imem_instr, PC}, PC<=PC+4.
  - imem_instr == 0: no push, PC unchanged, ->HALT.
- RUN, push not allowed: PC holds; no memory-side state change (stall).
- RUN, illegal PC: no push, ->FAULT. Checked before the zero test.
- Latency: the word at PC is pushed at edge N; instr_valid=1 from cycle N+1. Sustained throughput is 1 instr/cycle while instr_ready=1.
- Pop: occurs when instr_valid && instr_ready. instr_out/instr_pc are registered FIFO head, stable while instr_valid && !instr_ready.
- Simultaneous push+pop when full: both occur; count unchanged.
- Redirect (highest priority after reset), redirect_valid=1 at edge:
  - FIFO flushed (count<=0); any same-cycle push is suppressed.
  - A same-cycle pop counts as accepted by decode.
  - PC<=redirect_target.
  - HALT->RUN and RUN->RUN. FAULT is not exited; only reset clears FAULT.
  - Target legality is evaluated on the following cycle as a normal fetch.
- HALT: no fetch; PC holds at the zero word's address. FIFO keeps draining to decode. Exited by redirect or reset.
- FAULT: no fetch; FIFO keeps draining. fault=1 until reset.
- Reset mid-operation: overrides redirect/push/pop; FIFO contents discarded.
- PC arithmetic is 32-bit. Increment never overflows in practice because of the legality check.

Test Plan:
- Reset, instr_ready=1, memory holds 8C010000,8C020001,00220818,08000002,00221018,04240003,AC040004,1C61103F,00000000 -> 8 words delivered in order, instr_pc 0,4,...,28 on consecutive cycles; first instr_valid one cycle after reset release; halted=1 after PC=32 fetch; no 9th word.
- Same program, instr_ready=0 for 5 cycles -> FIFO fills at 2 entries (8C010000@0, 8C020001@4); imem_pc holds 8; raise ready -> stream resumes without loss or duplication.
- Redirect to 16 while PC=12 and FIFO holds 2 words -> FIFO flushed, next delivered word 00221018 with instr_pc=16; words at 8/12 never appear.
- In HALT at PC=32, pulse redirect to 0 -> halted=0 next cycle, 8C010000@0 re-delivered.
- Redirect to 0x22 (misaligned) -> fault=1 next cycle, no push; later redirect to 0 leaves fault=1; reset clears it.
- Redirect to 36 (PC+3 beyond MEM_BYTES) -> fault=1. Redirect coincident with a full-FIFO pop -> pop accepted, FIFO empty, PC=target.

Source files
------------

// File: rtl/imem_fetch_sequencer_if.sv
// imem_fetch_sequencer_if: bus between the fetch sequencer, instruction memory, redirect source and decode
//   master: fetch sequencer side (drives imem_pc, instr_* toward decode, halted, fault)
//   slave : environment side (drives imem_instr, redirect_*, instr_ready)
interface imem_fetch_sequencer_if;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        halted;
   logic        fault;
   modport master (
      output imem_pc, instr_valid, instr_out, instr_pc, halted, fault,
      input  imem_instr, redirect_valid, redirect_target, instr_ready
   );
   modport slave (
      input  imem_pc, instr_valid, instr_out, instr_pc, halted, fault,
      output imem_instr, redirect_valid, redirect_target, instr_ready
   );
endinterface

// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer: owns the PC, fetches words from a combinational imem into a small FIFO toward decode
//   clk, reset : clock and synchronous active-high reset
//   bus.master : imem_pc/imem_instr memory port, redirect_valid/redirect_target,
//                instr_valid/instr_ready/instr_out/instr_pc decode handshake, halted/fault status
module imem_fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_BYTES = 36,
   parameter int          QDEPTH    = 2
) (
   input logic                    clk,
   input logic                    reset,
   imem_fetch_sequencer_if.master bus
);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   typedef enum logic [1:0] {RUN, HALT, FAULT} state_e;
   state_e          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [31:0]     word_q [QDEPTH];
   logic [31:0]     addr_q [QDEPTH];
   logic            pop, push, legal, room;
   assign bus.imem_pc     = pc_q;
   assign bus.instr_valid = count_q != '0;
   assign bus.instr_out   = word_q[rd_ptr_q];
   assign bus.instr_pc    = addr_q[rd_ptr_q];
   assign bus.halted      = state_q == HALT;
   assign bus.fault       = state_q == FAULT;
   always_comb begin
      pop      = (count_q != '0) && bus.instr_ready;
      // 33-bit sum so a PC near the top of the address space cannot wrap into range
      legal    = (pc_q[1:0] == 2'b00) && (({1'b0, pc_q} + 33'd3) < 33'(MEM_BYTES));
      // a full FIFO still accepts a push when the head leaves in the same cycle
      room     = (count_q < CW'(QDEPTH)) || pop;
      push     = 1'b0;
      state_d  = state_q;
      pc_d     = pc_q;
      if (state_q == RUN) begin
         if (!legal)
            state_d = FAULT;
         else if (room) begin
            if (bus.imem_instr == 32'h0)
               state_d = HALT;
            else begin
               push = 1'b1;
               pc_d = pc_q + 32'd4;
            end
         end
      end
      if (bus.redirect_valid) begin
         push    = 1'b0;
         pc_d    = bus.redirect_target;
         state_d = (state_q == FAULT) ? FAULT : RUN;
      end
      rd_ptr_d = bus.redirect_valid ? '0 : rd_ptr_q + PW'(pop);
      wr_ptr_d = bus.redirect_valid ? '0 : wr_ptr_q + PW'(push);
      count_d  = bus.redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= RUN;
         pc_q     <= RESET_PC;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            word_q[i] <= '0;
            addr_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         if (push) begin
            word_q[wr_ptr_q] <= bus.imem_instr;
            addr_q[wr_ptr_q] <= pc_q;
         end
      end
   end
endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// tb_imem_fetch_sequencer: directed bench for imem_fetch_sequencer with a 36-byte program memory
module tb_imem_fetch_sequencer;
   localparam logic [31:0] PROG [9] = '{
      32'h8C010000, 32'h8C020001, 32'h00221018 - 32'h00000800, 32'h08000002, 32'h00221018,
      32'h04240003, 32'hAC040004, 32'h1C61103F, 32'h00000000
   };
   logic clk, reset;
   int   n_tests, n_fail;
   imem_fetch_sequencer_if bus ();
   imem_fetch_sequencer #(.RESET_PC(32'h0), .MEM_BYTES(36), .QDEPTH(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
   assign bus.imem_instr = (bus.imem_pc < 32'd36 && bus.imem_pc[1:0] == 2'b00) ?
                           PROG[bus.imem_pc[5:2]] : 32'hFFFF_FFFF;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask
   task automatic redirect(input logic [31:0] tgt);
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = tgt;
      tick();
      bus.redirect_valid  = 1'b0;
   endtask
   task automatic wait_halt();
      for (int i = 0; i < 12 && !bus.halted; i++) tick();
      chk("halt_reached", bus.halted, 1);
   endtask
   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = 32'h0;
      bus.instr_ready     = 1'b1;
      tick();
      tick();
      chk("rst_valid", bus.instr_valid, 0);
      chk("rst_out", bus.instr_out, 0);
      chk("rst_pc", bus.instr_pc, 0);
      chk("rst_halted", bus.halted, 0);
      chk("rst_fault", bus.fault, 0);
      chk("rst_imem_pc", bus.imem_pc, 0);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("stream_valid%0d", k), bus.instr_valid, 1);
         chk($sformatf("stream_out%0d", k), bus.instr_out, PROG[k]);
         chk($sformatf("stream_pc%0d", k), bus.instr_pc, 32'(4 * k));
      end
      tick();
      chk("end_halted", bus.halted, 1);
      chk("end_valid", bus.instr_valid, 0);
      chk("end_imem_pc", bus.imem_pc, 32);
      tick();
      chk("end_no9th", bus.instr_valid, 0);
      do_reset();
      bus.instr_ready = 1'b0;
      repeat (5) tick();
      chk("stall_valid", bus.instr_valid, 1);
      chk("stall_out", bus.instr_out, PROG[0]);
      chk("stall_pc", bus.instr_pc, 0);
      chk("stall_imem_pc", bus.imem_pc, 8);
      bus.instr_ready = 1'b1;
      for (int k = 1; k < 8; k++) begin
         tick();
         chk($sformatf("resume_out%0d", k), bus.instr_out, PROG[k]);
         chk($sformatf("resume_pc%0d", k), bus.instr_pc, 32'(4 * k));
      end
      do_reset();
      bus.instr_ready = 1'b0;
      tick();
      tick();
      bus.instr_ready = 1'b1;
      tick();
      bus.instr_ready = 1'b0;
      chk("pre_redir_imem_pc", bus.imem_pc, 12);
      chk("pre_redir_head_pc", bus.instr_pc, 4);
      redirect(32'd16);
      bus.instr_ready = 1'b1;
      chk("redir_flush", bus.instr_valid, 0);
      chk("redir_imem_pc", bus.imem_pc, 16);
      tick();
      chk("redir_out", bus.instr_out, 32'h00221018);
      chk("redir_pc", bus.instr_pc, 16);
      tick();
      chk("redir_next_pc", bus.instr_pc, 20);
      wait_halt();
      chk("halt_imem_pc", bus.imem_pc, 32);
      redirect(32'd0);
      chk("unhalt", bus.halted, 0);
      tick();
      chk("unhalt_out", bus.instr_out, PROG[0]);
      chk("unhalt_pc", bus.instr_pc, 0);
      redirect(32'h22);
      chk("mis_fault_early", bus.fault, 0);
      chk("mis_imem_pc", bus.imem_pc, 32'h22);
      tick();
      chk("mis_fault", bus.fault, 1);
      chk("mis_nopush", bus.instr_valid, 0);
      redirect(32'd0);
      chk("mis_sticky", bus.fault, 1);
      tick();
      chk("mis_sticky2", bus.fault, 1);
      chk("mis_nofetch", bus.instr_valid, 0);
      do_reset();
      chk("mis_cleared", bus.fault, 0);
      redirect(32'd36);
      chk("oob_imem_pc", bus.imem_pc, 36);
      tick();
      chk("oob_fault", bus.fault, 1);
      chk("oob_nopush", bus.instr_valid, 0);
      do_reset();
      bus.instr_ready = 1'b0;
      tick();
      tick();
      chk("full_head", bus.instr_out, PROG[0]);
      bus.instr_ready = 1'b1;
      redirect(32'd20);
      chk("popredir_empty", bus.instr_valid, 0);
      chk("popredir_imem_pc", bus.imem_pc, 20);
      tick();
      chk("popredir_out", bus.instr_out, PROG[5]);
      chk("popredir_pc", bus.instr_pc, 20);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
